// File: rtl/mem_arbiter_if.sv
// Signal bundle between the F/D requesters, the shared RAM and the memory arbiter.
// The arbiter binds to the slave modport; requesters and RAM together form the master side.
interface mem_arbiter_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        err;
    logic        ram_cs;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        ram_ready;
    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_dout, ram_ready,
        output f_ack, f_rdata, d_ack, d_rdata, err, ram_cs, ram_we, ram_addr, ram_din, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_dout, ram_ready,
        input  f_ack, f_rdata, d_ack, d_rdata, err, ram_cs, ram_we, ram_addr, ram_din, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch (F) and data (D).
// One access at a time: IDLE -> ISSUE -> (WAIT) -> RESP, with a bounded wait for read data.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        owner_q;   // 1 = D, 0 = F
    logic        last_q;    // last granted requester, same encoding
    logic        last_d;
    logic [7:0]  cnt_q;
    logic        f_ack_q, d_ack_q, err_q;
    logic        cs_q, we_q, busy_q;
    logic [15:0] addr_q, din_q;
    logic [15:0] f_rdata_q, d_rdata_q;

    // Under contention the requester that did not win last time is granted.
    always_comb begin
        last_d = last_q;
        if (bus.f_req && bus.d_req) last_d = ~last_q;
        else if (bus.d_req)         last_d = 1'b1;
        else if (bus.f_req)         last_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        owner_q <= last_d;
                        last_q  <= last_d;
                        cs_q    <= 1'b1;
                        we_q    <= last_d & bus.d_we;
                        addr_q  <= last_d ? bus.d_addr : bus.f_addr;
                        din_q   <= last_d ? bus.d_wdata : 16'h0000;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (we_q) begin
                        d_ack_q <= owner_q;
                        f_ack_q <= ~owner_q;
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ram_ready || cnt_q == CNT_LAST) begin
                        // A read that times out returns zero flagged with err.
                        if (owner_q) d_rdata_q <= bus.ram_ready ? bus.ram_dout : 16'h0000;
                        else         f_rdata_q <= bus.ram_ready ? bus.ram_dout : 16'h0000;
                        err_q   <= ~bus.ram_ready;
                        d_ack_q <= owner_q;
                        f_ack_q <= ~owner_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.f_ack    = f_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.err      = err_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.ram_cs   = cs_q;
    assign bus.ram_we   = we_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model with configurable read latency, transaction-level
// reference (grant order, ack deadline, expected data) checked every cycle, plus directed cases.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input logic [15:0] a);
        return 16'(a * 16'd13) ^ 16'h5A5A;
    endfunction

    // ---------------- RAM model ----------------
    // dmode: 0 = ready next cycle, 1 = random 0..TO+1 cycles, 2 = never, 3 = fixed 4
    int          dmode = 0;
    int          cur_delay = 0;
    logic [15:0] mem [0:65535];

    initial begin
        bit          pend_r;
        int          left;
        logic [15:0] rbuf;
        pend_r = 1'b0;
        left   = 0;
        rbuf   = '0;
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        bus.ram_ready = 1'b0;
        bus.ram_dout  = '0;
        forever begin
            @(posedge CLK);
            if (RST) begin
                pend_r = 1'b0;
            end else if (bus.ram_cs) begin
                pend_r = 1'b0;
                if (bus.ram_we) begin
                    mem[bus.ram_addr] = bus.ram_din;
                end else begin
                    case (dmode)
                        0:       cur_delay = 0;
                        1:       cur_delay = $urandom_range(0, TO + 1);
                        3:       cur_delay = 4;
                        default: cur_delay = 1000;
                    endcase
                    rbuf   = mem[bus.ram_addr];
                    left   = cur_delay;
                    pend_r = 1'b1;
                end
            end
            if (pend_r && left == 0) begin
                bus.ram_ready <= 1'b1;
                bus.ram_dout  <= rbuf;
                pend_r = 1'b0;
            end else begin
                bus.ram_ready <= 1'b0;
                bus.ram_dout  <= 16'($urandom);
                if (pend_r) left--;
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    bit          glog [$];     // grant order, 0 = F, 1 = D
    logic [15:0] shadow [0:65535];
    int          cyc = 0;
    bit          pv;
    bit          lg;
    bit          p_own, p_we, p_err;
    int          p_iss, p_ack;
    logic [15:0] p_addr, p_wd, p_dat;
    logic [15:0] efr, edr, eaddr;

    initial begin
        bit ecs, ewe, efa, eda, eerr, ebusy;
        for (int i = 0; i < 65536; i++) shadow[i] = pat(16'(i));
        pv = 0; lg = 1; efr = '0; edr = '0; eaddr = '0;
        p_own = 0; p_we = 0; p_err = 0; p_iss = 0; p_ack = 0;
        p_addr = '0; p_wd = '0; p_dat = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                pv = 0; lg = 1; efr = '0; edr = '0; eaddr = '0;
                chk("rst_ctl", 32'({bus.f_ack, bus.d_ack, bus.err, bus.ram_cs, bus.ram_we, bus.busy}), 0);
                chk("rst_addr_din", {bus.ram_addr, bus.ram_din}, 0);
                chk("rst_rdata", {bus.f_rdata, bus.d_rdata}, 0);
            end else begin
                ecs = 0; ewe = 0; efa = 0; eda = 0; eerr = 0; ebusy = pv;
                if (pv) begin
                    if (cyc == p_iss) begin
                        ecs   = 1;
                        ewe   = p_we;
                        eaddr = p_addr;
                        if (p_we) begin
                            shadow[p_addr] = p_wd;
                            chk("wr_din", 32'(bus.ram_din), 32'(p_wd));
                        end
                    end
                    if (!p_we && cyc == p_iss + 1) begin
                        if (cur_delay < TO) begin
                            p_ack = p_iss + 2 + cur_delay; p_dat = shadow[p_addr]; p_err = 0;
                        end else begin
                            p_ack = p_iss + 1 + TO; p_dat = '0; p_err = 1;
                        end
                    end
                    if (cyc == p_ack) begin
                        eerr = p_err;
                        if (p_own) eda = 1; else efa = 1;
                        if (!p_we) begin
                            if (p_own) edr = p_dat; else efr = p_dat;
                        end
                    end
                end
                chk("ram_cs",  32'(bus.ram_cs), 32'(ecs));
                chk("ram_we",  32'(bus.ram_we), 32'(ewe));
                chk("f_ack",   32'(bus.f_ack),  32'(efa));
                chk("d_ack",   32'(bus.d_ack),  32'(eda));
                chk("err",     32'(bus.err),    32'(eerr));
                chk("busy",    32'(bus.busy),   32'(ebusy));
                chk("ram_addr", 32'(bus.ram_addr), 32'(eaddr));
                chk("f_rdata", 32'(bus.f_rdata), 32'(efr));
                chk("d_rdata", 32'(bus.d_rdata), 32'(edr));
                if (pv && cyc == p_ack) begin
                    pv = 0;
                end else if (!pv && (bus.f_req || bus.d_req)) begin
                    if (bus.f_req && bus.d_req) p_own = ~lg;
                    else                        p_own = bus.d_req;
                    lg = p_own;
                    glog.push_back(p_own);
                    pv     = 1;
                    p_iss  = cyc + 1;
                    p_we   = p_own ? bus.d_we : 1'b0;
                    p_addr = p_own ? bus.d_addr : bus.f_addr;
                    p_wd   = bus.d_wdata;
                    p_err  = 0;
                    p_ack  = p_we ? cyc + 2 : 32'h7fffffff;
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic f_acc(input logic [15:0] a, input bit hold, output logic [15:0] dat, output logic e);
        int n = 0;
        @(posedge CLK); #1;
        bus.f_req = 1'b1; bus.f_addr = a;
        do begin @(negedge CLK); n++; end while (!bus.f_ack && n < 100);
        chk("f_ack_seen", 32'(bus.f_ack), 1);
        dat = bus.f_rdata; e = bus.err;
        if (!hold) begin @(posedge CLK); #1; bus.f_req = 1'b0; end
    endtask

    task automatic d_acc(input bit we, input logic [15:0] a, input logic [15:0] wd, input bit hold,
                         output logic [15:0] dat, output logic e);
        int n = 0;
        @(posedge CLK); #1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
        do begin @(negedge CLK); n++; end while (!bus.d_ack && n < 100);
        chk("d_ack_seen", 32'(bus.d_ack), 1);
        dat = bus.d_rdata; e = bus.err;
        if (!hold) begin @(posedge CLK); #1; bus.d_req = 1'b0; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] dat, dat2;
        logic        e, e2;
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // write, read back, fetch the same word
        dmode = 0;
        d_acc(1, 16'h3000, 16'h1234, 0, dat, e); chk("wr_err", 32'(e), 0);
        d_acc(0, 16'h3000, 16'h0, 0, dat, e);
        chk("rd_data", 32'(dat), 32'h1234); chk("rd_err", 32'(e), 0);
        f_acc(16'h3000, 0, dat, e);
        chk("fetch_data", 32'(dat), 32'h1234); chk("fetch_err", 32'(e), 0);

        // RAM never ready: timeout, then a normal access
        dmode = 2;
        d_acc(0, 16'h3000, 16'h0, 0, dat, e);
        chk("to_err", 32'(e), 1); chk("to_data", 32'(dat), 0);
        dmode = 0;
        d_acc(0, 16'h3000, 16'h0, 0, dat, e);
        chk("post_to_data", 32'(dat), 32'h1234); chk("post_to_err", 32'(e), 0);

        // contention with both requests held
        glog.delete();
        fork
            begin
                logic [15:0] x; logic y;
                f_acc(16'h3001, 1, x, y);
                f_acc(16'h3002, 0, x, y);
            end
            begin
                logic [15:0] x; logic y;
                d_acc(1, 16'h3003, 16'hBEEF, 1, x, y);
                d_acc(0, 16'h3003, 16'h0, 0, x, y);
                chk("cont_rd", 32'(x), 32'hBEEF);
            end
        join
        chk("cont_len", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("cont_order", 32'(glog[i]), 32'(i % 2));

        // D pulsed and then held while an F read waits
        dmode = 3;
        glog.delete();
        dat2 = '0;
        fork
            f_acc(16'h3004, 0, dat, e);
            begin
                int n = 0;
                repeat (3) @(posedge CLK);
                #1 bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h3000;
                @(posedge CLK); #1 bus.d_req = 0;
                @(posedge CLK); #1 bus.d_req = 1;
                do begin @(negedge CLK); n++; end while (!bus.d_ack && n < 100);
                chk("busy_d_ack", 32'(bus.d_ack), 1);
                dat2 = bus.d_rdata; e2 = bus.err;
                @(posedge CLK); #1 bus.d_req = 0;
            end
        join
        chk("busy_f_data", 32'(dat), 32'(pat(16'h3004)));
        chk("busy_d_data", 32'(dat2), 32'h1234);
        chk("busy_len", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("busy_first", 32'(glog[0]), 0);
            chk("busy_second", 32'(glog[1]), 1);
        end

        // reset during WAIT, then a tie goes to F
        dmode = 2;
        @(posedge CLK); #1 bus.f_req = 1; bus.f_addr = 16'h3005;
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1; bus.f_req = 0;
        @(negedge CLK);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_ack", 32'({bus.f_ack, bus.d_ack}), 0);
        @(posedge CLK); #1 RST = 1'b0;
        dmode = 0;
        glog.delete();
        fork
            begin logic [15:0] x; logic y; f_acc(16'h3000, 0, x, y); chk("rst_tie_f", 32'(x), 32'h1234); end
            begin logic [15:0] x; logic y; d_acc(0, 16'h3003, 16'h0, 0, x, y); chk("rst_tie_d", 32'(x), 32'hBEEF); end
        join
        chk("rst_tie_len", glog.size(), 2);
        if (glog.size() >= 1) chk("rst_tie_first", 32'(glog[0]), 0);

        // randomized traffic from both requesters
        dmode = 1;
        fork
            begin
                logic [15:0] x; logic y; int g, gn;
                g = $urandom_range(0, 3);
                for (int i = 0; i < 40; i++) begin
                    repeat (g) @(posedge CLK);
                    gn = (i == 39) ? 1 : $urandom_range(0, 3);
                    f_acc(16'h3000 + 16'($urandom_range(0, 15)), gn == 0, x, y);
                    g = gn;
                end
            end
            begin
                logic [15:0] x; logic y; int g, gn;
                g = $urandom_range(0, 3);
                for (int i = 0; i < 40; i++) begin
                    repeat (g) @(posedge CLK);
                    gn = (i == 39) ? 1 : $urandom_range(0, 3);
                    d_acc(1'($urandom_range(0, 1)), 16'h3000 + 16'($urandom_range(0, 15)),
                          16'($urandom), gn == 0, x, y);
                    g = gn;
                end
            end
        join

        repeat (5) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 16x64K RAM between the instruction-fetch requester (F) and the data (LD/ST) requester (D).
- Per requester: accepts a request, sequences the RAM chip-select/write-enable, waits for the RAM read-ready, and returns data with a one-cycle acknowledge.
- Sits between the control unit's MAR/MDR logic and the RAM.
- Ties are resolved round-robin. A timeout guards against a RAM that never signals ready.

Parameters:
- TIMEOUT, 8, maximum WAIT-state cycles before a read is aborted with error (range 1..255).

Ports:
- CLK  input  1  system clock, all state on posedge.
- RST  input  1  asynchronous, active-high reset.
- f_req  input  1  fetch request; held high with f_addr stable until f_ack.
- f_addr  input  16  fetch address (always a read).
- f_ack  output  1  one-cycle pulse: fetch complete.
- f_rdata  output  16  fetched word, valid while f_ack=1.
- d_req  input  1  data request; held with d_addr/d_we/d_wdata stable until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  16  data address.
- d_wdata  input  16  write data.
- d_ack  output  1  one-cycle pulse: data access complete.
- d_rdata  output  16  read data, valid while d_ack=1.
- err  output  1  valid with either ack: 1 = timeout abort.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_addr  output  16  RAM address.
- ram_din  output  16  RAM write data.
- ram_dout  input  16  RAM registered read data.
- ram_ready  input  1  RAM read-valid flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async on RST rising; held while RST=1):
  - state = IDLE.
  - All outputs 0, including f_rdata and d_rdata.
  - last_grant = D, so F wins the first tie.
  - Timeout counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant, latch owner, we (F forces 0), addr and wdata; update last_grant; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ram_cs = 1, ram_we = latched we, ram_addr/ram_din = latched values.
  - Write: next state RESP.
  - Read: next state WAIT with counter cleared.
- WAIT (read only):
  - ram_cs = 0.
  - If ram_ready = 1: capture ram_dout into owner's rdata, err = 0, go to RESP.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 without ready: rdata = 0, err = 1, go to RESP.
- RESP (exactly 1 cycle):
  - Owner's ack = 1; the other ack = 0.
  - Next state IDLE; arbitration resumes the following cycle.
- Latency from req sampled in IDLE at cycle n:
  - Write: ram_cs at n+1, ack at n+2.
  - Read with ready at n+2: ack at n+3.
- Outputs outside ISSUE:
  - ram_cs = 0 and ram_we = 0.
  - ram_addr and ram_din hold their last values (0 after reset).
- rdata holds its value after ack until the next read for that requester. err is 0 whenever neither ack is high.
- Requests that arrive while busy are ignored until IDLE; nothing is queued.
- A requester dropping req before its ack is a protocol violation: the access still completes and is acked.
- RST during any state:
  - Immediate return to IDLE, with no ack for the in-flight access.
  - A write already issued in ISSUE may have been committed to RAM.
- Back-to-back: the same requester holding req continuously after its ack is re-granted only if the other is idle. This gives fairness of one access per requester per turn under contention.

Test Plan:
- Reset: assert RST mid-WAIT → state IDLE, all outputs 0, no ack; after release, f_req wins the first tie.
- Single write then read: d_we=1, d_addr=0x3000, d_wdata=0x1234 → ram_cs/ram_we high 1 cycle, d_ack at n+2. Then read 0x3000 → d_ack at n+3 with d_rdata=0x1234, err=0.
- Fetch: f_req with f_addr=0x3000 after the write above → ram_we=0, f_ack at n+3, f_rdata=0x1234.
- Contention: f_req and d_req both held high for 4 accesses → grants alternate F, D, F, D; one ack per RESP; never both acks high.
- Timeout: ram_ready tied 0, read request with TIMEOUT=8 → ack with err=1, rdata=0x0000 after 8 WAIT cycles; next access proceeds normally.
- Busy ignore: d_req pulsed while an F read is in WAIT, then held → no second ram_cs until after f_ack; D served next.
